pc_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit CPU datapath. It owns the program counter and the instruction register. It steps each instruction through FETCH/EXEC/MEM/WB phases and gates the decoder's `regwrite`/`memwrite` so that each fires as a single-cycle strobe in the correct phase. It resolves jumps, branches and halt. It sits between the instruction memory, the control decoder, the ALU zero flag and the register-file/data-memory write enables.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/pc_sequencer_pc_next.sv | 27 ++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pc_sequencer slice. The optional
// breakpoint feature elsewhere is guarded by PC_SEQ_BREAKPOINT_EN.
package cpu_pkg;

  localparam int PC_W  = 16;
  localparam int IMM_W = 7;

  localparam logic [PC_W-1:0] HALT_INSN_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } seq_state_t;

  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer (slave) and imem/decoder/ALU side (master).
// PC_SEQ_BREAKPOINT_EN adds the bp_addr/bp_resume pair.
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic            run;
  logic [PC_W-1:0] instr_in;
  logic            jump;
  logic            branch;
  logic            memwrite;
  logic            regwrite;
  logic            memtoreg;
  logic            is_zero;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ir;
  logic            regwrite_o;
  logic            memwrite_o;
  logic            halted;
  logic [2:0]      state_o;
`ifdef PC_SEQ_BREAKPOINT_EN
  logic [PC_W-1:0] bp_addr;
  logic            bp_resume;
`endif

  modport slave (
`ifdef PC_SEQ_BREAKPOINT_EN
    input  bp_addr, bp_resume,
`endif
    input  run, instr_in, jump, branch, memwrite, regwrite, memtoreg, is_zero,
    output pc, ir, regwrite_o, memwrite_o, halted, state_o
  );

  modport master (
`ifdef PC_SEQ_BREAKPOINT_EN
    output bp_addr, bp_resume,
`endif
    output run, instr_in, jump, branch, memwrite, regwrite, memtoreg, is_zero,
    input  pc, ir, regwrite_o, memwrite_o, halted, state_o
  );

endinterface

// File: rtl/pc_sequencer_pc_next.sv
// Combinational next-PC select: jump, taken branch (sign-extended offset),
// or plain increment. All arithmetic wraps modulo 2^PC_W.
module pc_next
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-4:0] ir_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] pc_inc;

  always_comb begin
    pc_inc = pc_i + PC_W'(1);
    // Jump keeps the top three PC bits, so targets stay inside the current 8K page.
    if (jump_i)
      next_pc_o = {pc_i[PC_W-1:PC_W-3], ir_i};
    else if (branch_i && zero_i)
      next_pc_o = pc_inc + sext_imm(ir_i[IMM_W-1:0]);
    else
      next_pc_o = pc_inc;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning pc and ir, emitting one-cycle
// write strobes. Optional fetch breakpoint under PC_SEQ_BREAKPOINT_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [PC_W-1:0] HALT_INSN = HALT_INSN_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ir_q, ir_d;
  logic            z_q, z_d;
  logic            regwrite_q, regwrite_d;
  logic            memwrite_q, memwrite_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] next_pc;
  logic            fetch_stall;

  pc_next u_pc_next (
    .pc_i      (pc_q),
    .ir_i      (ir_q[PC_W-4:0]),
    .jump_i    (bus.jump),
    .branch_i  (bus.branch),
    .zero_i    (z_q),
    .next_pc_o (next_pc)
  );

`ifdef PC_SEQ_BREAKPOINT_EN
  assign fetch_stall = (pc_q == bus.bp_addr) && !bus.bp_resume;
`else
  assign fetch_stall = 1'b0;
`endif

  // Strobes are computed on the transition into MEM/WB so they are registered
  // and live for exactly the one cycle spent in that state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    z_d        = z_q;
    regwrite_d = 1'b0;
    memwrite_d = 1'b0;
    halted_d   = halted_q;
    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        if (!fetch_stall) begin
          ir_d = bus.instr_in;
          if (bus.instr_in == HALT_INSN) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        z_d = bus.is_zero;
        if (bus.memwrite || bus.memtoreg) begin
          state_d    = MEM;
          memwrite_d = bus.memwrite;
        end else begin
          state_d    = WB;
          regwrite_d = bus.regwrite;
        end
      end
      MEM: begin
        state_d    = WB;
        regwrite_d = bus.regwrite;
      end
      WB: begin
        pc_d    = next_pc;
        state_d = bus.run ? FETCH : IDLE;
      end
      HALT: begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      z_q        <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      z_q        <= z_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.regwrite_o = regwrite_q;
  assign bus.memwrite_o = memwrite_q;
  assign bus.halted     = halted_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-instruction expectations are queued
// when driven and popped when the instruction retires.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus_if ();

  pc_sequencer #(.RESET_PC(16'h0000), .HALT_INSN(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    int          len;
    int          rw_cyc;
    int          mw_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input string tag);
    int n = 0;
    while (bus_if.state_o !== 3'd1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fetch"}, bus_if.state_o, 3'd1);
  endtask

  // Entered in the FETCH cycle of the instruction; returns in the first cycle
  // after WB (next FETCH, or IDLE when run was dropped).
  task automatic do_insn(input string tag, input logic [15:0] instr,
                         input logic j, input logic b, input logic mw,
                         input logic rw, input logic mtr, input logic z,
                         input logic [15:0] exp_pc, input bit drop_run);
    exp_t e;
    exp_t got;
    int   k;
    bit   done;
    logic [15:0] pc_after;
    wait_fetch(tag);
    bus_if.instr_in = instr;
    bus_if.jump     = j;
    bus_if.branch   = b;
    bus_if.memwrite = mw;
    bus_if.regwrite = rw;
    bus_if.memtoreg = mtr;
    bus_if.is_zero  = z;
    e.tag    = tag;
    e.pc     = exp_pc;
    e.len    = (mw || mtr) ? 4 : 3;
    e.rw_cyc = rw ? e.len : 0;
    e.mw_cyc = mw ? 3 : 0;
    sb.push_back(e);
    got.tag = tag; got.rw_cyc = 0; got.mw_cyc = 0;
    k = 1;
    done = 0;
    while (!done && k < 10) begin
      if (bus_if.regwrite_o === 1'b1) got.rw_cyc = (got.rw_cyc == 0) ? k : -1;
      if (bus_if.memwrite_o === 1'b1) got.mw_cyc = (got.mw_cyc == 0) ? k : -1;
      if (k == 2) check({tag, "_ir"}, bus_if.ir, instr);
      if (k == 2 && drop_run) bus_if.run = 1'b0;
      // is_zero only matters during EXEC; disturb it afterwards
      if (k == 3) bus_if.is_zero = ~z;
      @(negedge clk);
      k++;
      if (bus_if.state_o == 3'd1 || bus_if.state_o == 3'd0 || bus_if.state_o == 3'd5)
        done = 1;
    end
    if (bus_if.regwrite_o === 1'b1) got.rw_cyc = -1;
    if (bus_if.memwrite_o === 1'b1) got.mw_cyc = -1;
    got.len = k - 1;
    got.pc  = bus_if.pc;
    e = sb.pop_front();
    check({e.tag, "_len"}, got.len, e.len);
    check({e.tag, "_pc"}, got.pc, e.pc);
    check({e.tag, "_rw_cycle"}, got.rw_cyc, e.rw_cyc);
    check({e.tag, "_mw_cycle"}, got.mw_cyc, e.mw_cyc);
    if (drop_run) begin
      check({tag, "_idle"}, bus_if.state_o, 3'd0);
      pc_after = bus_if.pc;
      @(negedge clk);
      check({tag, "_idle_hold"}, bus_if.state_o, 3'd0);
      check({tag, "_pc_hold"}, bus_if.pc, pc_after);
      bus_if.run = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_if.run = 1'b0;
    bus_if.instr_in = 16'h0000;
    bus_if.jump = 1'b0;
    bus_if.branch = 1'b0;
    bus_if.memwrite = 1'b0;
    bus_if.regwrite = 1'b0;
    bus_if.memtoreg = 1'b0;
    bus_if.is_zero = 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
    bus_if.bp_addr = 16'h0000;
    bus_if.bp_resume = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("rst_pc", bus_if.pc, 16'h0000);
    check("rst_ir", bus_if.ir, 16'h0000);
    check("rst_rw", bus_if.regwrite_o, 1'b0);
    check("rst_mw", bus_if.memwrite_o, 1'b0);
    check("rst_halted", bus_if.halted, 1'b0);
    check("rst_state", bus_if.state_o, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_run", bus_if.state_o, 3'd0);
    bus_if.run = 1'b1;

    //       tag         instr     j     b     mw    rw    mtr   z     exp_pc    drop
    do_insn("alu0",     16'h0410, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);
    do_insn("jmp5",     16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0);
    do_insn("store5",   16'h8005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b0);
    do_insn("jmp10",    16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0);
    do_insn("br_taken", 16'h007E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000F, 1'b0);
    do_insn("jmp10b",   16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0);
    do_insn("br_not",   16'h007E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011, 1'b0);
    do_insn("jmp0",     16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_insn("br_neg",   16'h007E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    do_insn("wrap",     16'h0410, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_insn("br_neg2",  16'h007E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    do_insn("jmpE000",  16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hE000, 1'b0);
    do_insn("jmp_br",   16'h3ABC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFABC, 1'b0);
    do_insn("load",     16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFABD, 1'b0);
    do_insn("run_drop", 16'h0410, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFABE, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_pc", bus_if.pc, 16'h0000);
    do_insn("alu_a",    16'h0410, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);
    do_insn("alu_b",    16'h0411, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0);
    do_insn("alu_c",    16'h0412, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0);

    wait_fetch("halt");
    bus_if.instr_in = 16'hFFFF;
    bus_if.jump = 1'b0;
    bus_if.branch = 1'b0;
    bus_if.memtoreg = 1'b0;
    bus_if.regwrite = 1'b1;
    bus_if.memwrite = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_pc", bus_if.pc, 16'h0003);
      check("halt_flag", bus_if.halted, 1'b1);
      check("halt_state", bus_if.state_o, 3'd5);
      check("halt_strobes", {bus_if.regwrite_o, bus_if.memwrite_o}, 2'b00);
    end
    check("halt_ir", bus_if.ir, 16'hFFFF);

    bus_if.run = 1'b0;
    bus_if.memwrite = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("unhalt_pc", bus_if.pc, 16'h0000);
    check("unhalt_flag", bus_if.halted, 1'b0);
    check("unhalt_state", bus_if.state_o, 3'd0);

    bus_if.run = 1'b1;
    wait_fetch("mid_rst");
    bus_if.instr_in = 16'h0410;
    bus_if.regwrite = 1'b1;
    @(negedge clk);
    check("mid_rst_exec", bus_if.state_o, 3'd2);
    rst = 1'b1;
    bus_if.run = 1'b0;
    @(negedge clk);
    check("mid_rst_rw", bus_if.regwrite_o, 1'b0);
    check("mid_rst_state", bus_if.state_o, 3'd0);
    check("mid_rst_pc", bus_if.pc, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rw_after", bus_if.regwrite_o, 1'b0);
    check("mid_rst_idle", bus_if.state_o, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
